// File: rtl/fifo_uart_bridge.sv
// Drains 16-bit words from a FIFO and feeds them byte by byte to a UART transmitter.
// Default build sends two raw bytes per word; define ASCII_HEX_EN for four hex digits plus CR LF.
module fifo_uart_bridge #(
    parameter int RD_LAT = 1
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] fifo_q,
    input  logic        fifo_rdempty,
    output logic        fifo_rdreq,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_wr_en,
    output logic        active,
    output logic [15:0] word_count
);

`ifdef ASCII_HEX_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 2;
`endif
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [1:0] LAT_EXTRA = 2'(RD_LAT - 1);
    localparam logic [1:0] TMO_LAST = 2'd3;

    // Handshakes: fifo_rdreq and tx_wr_en are single-cycle registered pulses; a new
    // byte is only offered while tx_busy is low, and a byte counts as taken once
    // tx_busy has risen and fallen again, or stayed low for four cycles.
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_Q,
        LOAD,
        SEND,
        WAIT_TX
    } state_t;

    state_t           state;
    logic [15:0]      hold;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lat_cnt;
    logic [1:0]       tmo_cnt;
    logic             busy_seen;
    logic [7:0]       next_byte;
    logic             byte_done;

`ifdef ASCII_HEX_EN
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    always_comb begin
        next_byte = 8'h0A;
        case (idx)
            3'd0:    next_byte = hex_char(hold[15:12]);
            3'd1:    next_byte = hex_char(hold[11:8]);
            3'd2:    next_byte = hex_char(hold[7:4]);
            3'd3:    next_byte = hex_char(hold[3:0]);
            3'd4:    next_byte = 8'h0D;
            default: next_byte = 8'h0A;
        endcase
    end
`else
    always_comb begin
        next_byte = idx[0] ? hold[7:0] : hold[15:8];
    end
`endif

    // A byte whose busy pulse never shows up is treated as sent after the timeout.
    assign byte_done = (state == WAIT_TX) &&
                       (busy_seen ? !tx_busy : (!tx_busy && tmo_cnt == TMO_LAST));

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold       <= '0;
            idx        <= '0;
            lat_cnt    <= '0;
            tmo_cnt    <= '0;
            busy_seen  <= 1'b0;
            fifo_rdreq <= 1'b0;
            tx_data    <= '0;
            tx_wr_en   <= 1'b0;
            active     <= 1'b0;
            word_count <= '0;
        end else begin
            fifo_rdreq <= 1'b0;
            tx_wr_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !fifo_rdempty && !tx_busy) begin
                        state      <= READ;
                        fifo_rdreq <= 1'b1;
                        active     <= 1'b1;
                    end
                end
                READ: begin
                    state   <= WAIT_Q;
                    lat_cnt <= '0;
                end
                WAIT_Q: begin
                    if (lat_cnt == LAT_EXTRA) begin
                        state <= LOAD;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                LOAD: begin
                    hold  <= fifo_q;
                    idx   <= '0;
                    state <= SEND;
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_data   <= next_byte;
                        tx_wr_en  <= 1'b1;
                        tmo_cnt   <= '0;
                        busy_seen <= 1'b0;
                        state     <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (byte_done) begin
                        if (idx == LAST_IDX) begin
                            word_count <= word_count + 16'd1;
                            active     <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SEND;
                        end
                    end else if (!busy_seen) begin
                        if (tx_busy) begin
                            busy_seen <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
